// File: rtl/game_pkg.sv
// Shared types and elaboration-time helpers for the Whac-A-Mole game sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNTDOWN,
    ST_PLAY,
    ST_PAUSED,
    ST_GAME_OVER
  } state_t;

  typedef enum logic {
    PH_DOWN,
    PH_UP
  } phase_t;

  localparam int MS_PER_SEC = 1000;

  // Bits needed to hold the values 0..max_value.
  function automatic int width_of(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

  // Bits needed to index n items.
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Signed arithmetic so an over-large level*step clamps to the floor instead of wrapping.
  function automatic int phase_ms(input int start_ms, input int lvl, input int step_ms,
                                  input int min_ms);
    int len;
    len = start_ms - lvl * step_ms;
    return (len < min_ms) ? min_ms : len;
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Control/status bundle between the game sequencer and its button/display neighbours.
interface game_sequencer_if #(
  parameter int GAME_LENGTH_SECONDS = 20,
  parameter int COUNTDOWN_SECONDS   = 3,
  parameter int NUM_LEVELS          = 4
);
  import game_pkg::*;

  localparam int TW = width_of(GAME_LENGTH_SECONDS);
  localparam int CW = width_of(COUNTDOWN_SECONDS);
  localparam int LW = sel_width(NUM_LEVELS);

  logic          start_pressed;
  logic          abort_pressed;
  logic          pause_pressed;
  logic          game_in_progress;
  logic          game_over;
  logic          clear_scores;
  logic          mole_up;
  logic          mole_tick;
  logic [TW-1:0] timer_seconds;
  logic [CW-1:0] countdown;
  logic [LW-1:0] level;

  modport master (
    output start_pressed, abort_pressed, pause_pressed,
    input  game_in_progress, game_over, clear_scores, mole_up, mole_tick,
    input  timer_seconds, countdown, level
  );

  modport slave (
    input  start_pressed, abort_pressed, pause_pressed,
    output game_in_progress, game_over, clear_scores, mole_up, mole_tick,
    output timer_seconds, countdown, level
  );

endinterface

// File: rtl/game_sequencer_ms_tick_gen.sv
// Millisecond prescaler: counts CLK_PER_MS enabled cycles, pulses o_ms_tick on the last one.
module ms_tick_gen #(
  parameter int CLK_PER_MS = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_ms_tick
);
  import game_pkg::*;

  localparam int CW = width_of(CLK_PER_MS - 1);

  logic [CW-1:0] r_count;
  logic          w_wrap;

  assign w_wrap    = (r_count == CW'(CLK_PER_MS - 1));
  assign o_ms_tick = i_enable && w_wrap;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_wrap ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Whac-A-Mole game controller: IDLE -> COUNTDOWN -> PLAY -> GAME_OVER, ms/second timebase and
// level-scaled mole phases. Define GAME_PAUSE_EN to add a PAUSED state toggled by pause_pressed.
module game_sequencer #(
  parameter int CLK_PER_MS          = 50000,
  parameter int GAME_LENGTH_SECONDS = 20,
  parameter int COUNTDOWN_SECONDS   = 3,
  parameter int NUM_LEVELS          = 4,
  parameter int LEVEL_SECONDS       = 5,
  parameter int MOLE_UP_MS_START    = 1000,
  parameter int MOLE_DOWN_MS_START  = 1000,
  parameter int MS_STEP             = 150,
  parameter int MIN_PHASE_MS        = 200
) (
  input  logic            clk,
  input  logic            rst,
  game_sequencer_if.slave bus
);
  import game_pkg::*;

  localparam int TW        = width_of(GAME_LENGTH_SECONDS);
  localparam int CW        = width_of(COUNTDOWN_SECONDS);
  localparam int LW        = sel_width(NUM_LEVELS);
  localparam int LSW       = width_of(LEVEL_SECONDS - 1);
  localparam int MSW       = width_of(MS_PER_SEC - 1);
  localparam int START_MAX = (MOLE_UP_MS_START > MOLE_DOWN_MS_START) ? MOLE_UP_MS_START
                                                                     : MOLE_DOWN_MS_START;
  localparam int PW        = width_of((START_MAX > MIN_PHASE_MS) ? START_MAX : MIN_PHASE_MS);
  localparam int NTBL      = 2 ** LW;

  state_t        r_state, w_state_next;
  phase_t        r_phase, w_phase_next;
  logic [TW-1:0] r_timer, w_timer_next;
  logic [CW-1:0] r_countdown, w_countdown_next;
  logic [LW-1:0] r_level, w_level_next;
  logic [LSW-1:0] r_lvl_sec, w_lvl_sec_next;
  logic [MSW-1:0] r_ms_cnt;
  logic [PW-1:0] r_phase_cnt, w_phase_cnt_next;
  logic [PW-1:0] r_phase_last, w_phase_last_next;
  logic          r_mole_up, w_mole_up_next;
  logic          r_mole_tick, w_mole_tick_next;
  logic          r_clear, w_clear_next;
  logic          r_gip, r_over;
  logic          w_reload, w_tb_en, w_ms_tick, w_sec_tick;

  // Last ms index of each phase per level; indices past the top level repeat it.
  logic [PW-1:0] w_up_last   [NTBL];
  logic [PW-1:0] w_down_last [NTBL];
  for (genvar gi = 0; gi < NTBL; gi++) begin : g_phase_tbl
    localparam int LVL = (gi < NUM_LEVELS) ? gi : NUM_LEVELS - 1;
    assign w_up_last[gi]   = PW'(phase_ms(MOLE_UP_MS_START, LVL, MS_STEP, MIN_PHASE_MS) - 1);
    assign w_down_last[gi] = PW'(phase_ms(MOLE_DOWN_MS_START, LVL, MS_STEP, MIN_PHASE_MS) - 1);
  end

  assign w_tb_en    = (r_state == ST_COUNTDOWN) || (r_state == ST_PLAY);
  assign w_sec_tick = w_ms_tick && (r_ms_cnt == MSW'(MS_PER_SEC - 1));

  ms_tick_gen #(.CLK_PER_MS(CLK_PER_MS)) u_ms_tick (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_reload),
    .i_enable  (w_tb_en),
    .o_ms_tick (w_ms_tick)
  );

`ifndef GAME_PAUSE_EN
  logic w_unused_pause;
  assign w_unused_pause = bus.pause_pressed;
`endif

  always_comb begin
    w_state_next      = r_state;
    w_timer_next      = r_timer;
    w_countdown_next  = r_countdown;
    w_level_next      = r_level;
    w_lvl_sec_next    = r_lvl_sec;
    w_phase_next      = r_phase;
    w_phase_cnt_next  = r_phase_cnt;
    w_phase_last_next = r_phase_last;
    w_mole_up_next    = r_mole_up;
    w_mole_tick_next  = 1'b0;
    w_clear_next      = 1'b0;
    w_reload          = 1'b0;
    if (bus.abort_pressed) begin
      w_state_next     = ST_IDLE;
      w_timer_next     = TW'(GAME_LENGTH_SECONDS);
      w_countdown_next = CW'(COUNTDOWN_SECONDS);
      w_level_next     = '0;
      w_lvl_sec_next   = '0;
      w_phase_next     = PH_DOWN;
      w_phase_cnt_next = '0;
      w_mole_up_next   = 1'b0;
      w_reload         = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_GAME_OVER: begin
          if (bus.start_pressed) begin
            w_state_next     = ST_COUNTDOWN;
            w_clear_next     = 1'b1;
            w_reload         = 1'b1;
            w_timer_next     = TW'(GAME_LENGTH_SECONDS);
            w_countdown_next = CW'(COUNTDOWN_SECONDS);
            w_level_next     = '0;
            w_lvl_sec_next   = '0;
            w_mole_up_next   = 1'b0;
          end
        end
        ST_COUNTDOWN: begin
          if (w_sec_tick) begin
            if (r_countdown <= CW'(1)) begin
              w_state_next      = ST_PLAY;
              w_countdown_next  = '0;
              w_reload          = 1'b1;
              w_phase_next      = PH_DOWN;
              w_phase_cnt_next  = '0;
              w_phase_last_next = w_down_last[0];
            end else begin
              w_countdown_next = r_countdown - CW'(1);
            end
          end
        end
        ST_PLAY: begin
          if (w_sec_tick) begin
            w_timer_next = r_timer - TW'(1);
            if (r_lvl_sec == LSW'(LEVEL_SECONDS - 1)) begin
              w_lvl_sec_next = '0;
              if (r_level < LW'(NUM_LEVELS - 1)) w_level_next = r_level + LW'(1);
            end else begin
              w_lvl_sec_next = r_lvl_sec + LSW'(1);
            end
          end
          if (w_sec_tick && (r_timer == TW'(1))) begin
            w_state_next   = ST_GAME_OVER;
            w_mole_up_next = 1'b0;
          end else begin
            // A phase starting on a level-change edge already uses the new level.
            if (w_ms_tick) begin
              if (r_phase_cnt == r_phase_last) begin
                w_phase_cnt_next = '0;
                if (r_phase == PH_DOWN) begin
                  w_phase_next      = PH_UP;
                  w_phase_last_next = w_up_last[w_level_next];
                  w_mole_up_next    = 1'b1;
                  w_mole_tick_next  = 1'b1;
                end else begin
                  w_phase_next      = PH_DOWN;
                  w_phase_last_next = w_down_last[w_level_next];
                  w_mole_up_next    = 1'b0;
                end
              end else begin
                w_phase_cnt_next = r_phase_cnt + PW'(1);
              end
            end
`ifdef GAME_PAUSE_EN
            if (bus.pause_pressed) w_state_next = ST_PAUSED;
`endif
          end
        end
`ifdef GAME_PAUSE_EN
        ST_PAUSED: begin
          if (bus.pause_pressed) w_state_next = ST_PLAY;
        end
`endif
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer      <= TW'(GAME_LENGTH_SECONDS);
      r_countdown  <= CW'(COUNTDOWN_SECONDS);
      r_level      <= '0;
      r_lvl_sec    <= '0;
      r_ms_cnt     <= '0;
      r_phase      <= PH_DOWN;
      r_phase_cnt  <= '0;
      r_phase_last <= w_down_last[0];
      r_mole_up    <= 1'b0;
      r_mole_tick  <= 1'b0;
      r_clear      <= 1'b0;
      r_gip        <= 1'b0;
      r_over       <= 1'b0;
    end else begin
      r_timer      <= w_timer_next;
      r_countdown  <= w_countdown_next;
      r_level      <= w_level_next;
      r_lvl_sec    <= w_lvl_sec_next;
      r_phase      <= w_phase_next;
      r_phase_cnt  <= w_phase_cnt_next;
      r_phase_last <= w_phase_last_next;
      r_mole_up    <= w_mole_up_next;
      r_mole_tick  <= w_mole_tick_next;
      r_clear      <= w_clear_next;
      r_gip        <= (w_state_next == ST_PLAY);
      r_over       <= (w_state_next == ST_GAME_OVER);
      if (w_reload) begin
        r_ms_cnt <= '0;
      end else if (w_ms_tick) begin
        r_ms_cnt <= w_sec_tick ? '0 : r_ms_cnt + MSW'(1);
      end
    end
  end

  assign bus.game_in_progress = r_gip;
  assign bus.game_over        = r_over;
  assign bus.clear_scores     = r_clear;
  assign bus.mole_up          = r_mole_up;
  assign bus.mole_tick        = r_mole_tick;
  assign bus.timer_seconds    = r_timer;
  assign bus.countdown        = r_countdown;
  assign bus.level            = r_level;

endmodule
